// File: rtl/reg_chain_checker_if.sv
// Tap bundle between a harness and the reg_chain_checker: sampled chain
// stimulus/output in, compare status and first-failure capture out.
interface reg_chain_checker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  en;
  logic [DATA_WIDTH-1:0] i;
  logic [DATA_WIDTH-1:0] o;
  logic                  clr;
  logic                  err;
  logic                  err_sticky;
  logic [CNT_WIDTH-1:0]  chk_cnt;
  logic [CNT_WIDTH-1:0]  err_cnt;
  logic [DATA_WIDTH-1:0] first_exp;
  logic [DATA_WIDTH-1:0] first_got;

  modport master (
    output en, i, o, clr,
    input  err, err_sticky, chk_cnt, err_cnt, first_exp, first_got
  );

  modport slave (
    input  en, i, o, clr,
    output err, err_sticky, chk_cnt, err_cnt, first_exp, first_got
  );
endinterface

// File: rtl/reg_chain_checker.sv
// Receive-side checker for the two-register chain: a 2-stage reference model
// aligned to the chain's latency, compared against the observed output.
module reg_chain_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  reg_chain_checker_if.slave  bus
);
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  localparam data_t ONE     = data_t'(1);
  localparam cnt_t  CNT_ONE = cnt_t'(1);
  localparam cnt_t  CNT_MAX = '1;

  logic  v1_q, v1_d;
  logic  v2_q, v2_d;
  data_t a1_q, a1_d;
  data_t exp2_q, exp2_d;
  logic  err_q, err_d;
  logic  err_sticky_q, err_sticky_d;
  cnt_t  chk_cnt_q, chk_cnt_d;
  cnt_t  err_cnt_q, err_cnt_d;
  data_t first_exp_q, first_exp_d;
  data_t first_got_q, first_got_d;

  logic  cmp;
  logic  mism;

  // Reference pipeline mirrors the chain's r0/r1 stages; en only tags validity.
  always_comb begin
    v1_d   = bus.en;
    a1_d   = bus.i + ONE;
    v2_d   = v1_q;
    exp2_d = (a1_q ^ ONE) + ONE + a1_q;
  end

  always_comb begin
    cmp  = v2_q;
    mism = v2_q && (bus.o != exp2_q);
  end

  // clr beats a same-cycle compare for the status state, but err still pulses.
  always_comb begin
    err_d        = mism;
    err_sticky_d = err_sticky_q;
    chk_cnt_d    = chk_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_exp_d  = first_exp_q;
    first_got_d  = first_got_q;
    if (bus.clr) begin
      err_sticky_d = 1'b0;
      chk_cnt_d    = '0;
      err_cnt_d    = '0;
      first_exp_d  = '0;
      first_got_d  = '0;
    end else begin
      if (cmp && (chk_cnt_q != CNT_MAX))
        chk_cnt_d = chk_cnt_q + CNT_ONE;
      if (mism && (err_cnt_q != CNT_MAX))
        err_cnt_d = err_cnt_q + CNT_ONE;
      if (mism && !err_sticky_q) begin
        first_exp_d  = exp2_q;
        first_got_d  = bus.o;
        err_sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      a1_q         <= '0;
      exp2_q       <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      chk_cnt_q    <= '0;
      err_cnt_q    <= '0;
      first_exp_q  <= '0;
      first_got_q  <= '0;
    end else begin
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      a1_q         <= a1_d;
      exp2_q       <= exp2_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      chk_cnt_q    <= chk_cnt_d;
      err_cnt_q    <= err_cnt_d;
      first_exp_q  <= first_exp_d;
      first_got_q  <= first_got_d;
    end
  end

  assign bus.err        = err_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.chk_cnt    = chk_cnt_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.first_exp  = first_exp_q;
  assign bus.first_got  = first_got_q;
endmodule

// File: doc/reg_chain_checker.md
Name: reg_chain_checker

Overview:
- Receive-side checker for the two-register extracted-subunit chain, i.e. the block whose `o` is a delayed function of `i`.
- Taps the chain's input stimulus and output, runs its own reference model with the same 2-cycle latency, and compares every enabled sample.
- Reports per-cycle mismatch pulses, sticky status, saturating counters and the first failing pair.
- Sits beside the chain in test harnesses and in-system self-check wrappers.

Parameters:
- DATA_WIDTH, 8, width of monitored `i`/`o` data.
- CNT_WIDTH, 16, width of the check and error counters.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  sample `i` this cycle for checking 2 cycles later.
- i  in  DATA_WIDTH  stimulus presented to the monitored chain.
- o  in  DATA_WIDTH  output of the monitored chain.
- clr  in  1  synchronous clear of counters, sticky flag and capture.
- err  out  1  registered pulse: a mismatch was detected on the previous edge's compare.
- err_sticky  out  1  set on first mismatch; held until reset or `clr`.
- chk_cnt  out  CNT_WIDTH  number of compares performed, saturating.
- err_cnt  out  CNT_WIDTH  number of mismatches, saturating.
- first_exp  out  DATA_WIDTH  expected value at the first mismatch.
- first_got  out  DATA_WIDTH  observed `o` at the first mismatch.

Behaviour:
- Reset:
  - On an edge with rst_n=0, every register clears to 0: v1, v2, a1, exp2, err, err_sticky, chk_cnt, err_cnt, first_exp, first_got.
  - Reset overrides `clr` and any compare in the same cycle.
- Reference model, all arithmetic mod 2^DATA_WIDTH:
  - Stage 1: a1 <= i + 1; v1 <= en.
  - Stage 2: exp2 <= (a1 XOR 1) + 1 + a1; v2 <= v1.
  - Latency: `i` sampled at edge t is compared against `o` present before edge t+2, matching the chain's r0/r1 timing.
- Compare:
  - Each cycle with v2=1, compare `o` to exp2.
  - Mismatch means err <= 1 next edge; otherwise err <= 0.
  - When v2=0, no compare occurs and err <= 0.
- Counters:
  - chk_cnt += 1 per compare; err_cnt += 1 per mismatch.
  - Both saturate at all-ones; they never wrap.
- First capture:
  - On a mismatch while err_sticky=0, load first_exp <= exp2 and first_got <= o, and set err_sticky.
  - Later mismatches do not overwrite the capture.
- Warm-up:
  - After reset, v1 and v2 are 0, so the first two cycles are never compared.
  - The chain's post-reset outputs (0, then 2) therefore never raise false errors.
- en gaps:
  - A sample with en=0 is skipped exactly.
  - Neighbouring samples are still checked at their own 2-cycle latency; there is no re-alignment.
- clr:
  - Zeroes chk_cnt, err_cnt, err_sticky, first_exp and first_got.
  - Does not flush the v1/v2/a1/exp2 pipeline.
  - If a compare happens in the same cycle as clr, clr wins: counters and capture end at 0, and that mismatch is not recorded.
  - err still pulses if that compare mismatched.
- Reset mid-stream: in-flight samples are discarded and no compare occurs for 2 cycles.

Test Plan:
1. Matching chain output:
   - Stimulus: reset, then en=1 with i=0,5,0xFF,0x80; drive o=2,14,2,2 two cycles after each sample.
   - Required: err stays 0, chk_cnt=4, err_cnt=0, err_sticky=0.
2. Single corruption:
   - Stimulus: i=5, drive o=15 instead of 14.
   - Required: err=1 for exactly one cycle, err_sticky=1, err_cnt=1, first_exp=14, first_got=15.
   - A later mismatch (i=0, o=3) gives err_cnt=2 while first_exp and first_got stay 14 and 15.
3. Warm-up and en gaps:
   - Stimulus: after reset, o=0 then o=2 with en=0; then the pattern en=1,0,1.
   - Required: no compare during warm-up; chk_cnt=2; the en=0 slot is never compared.
4. Saturation:
   - Stimulus: CNT_WIDTH=4, force continuous mismatches for 20 cycles.
   - Required: err_cnt and chk_cnt stop at 15 and do not wrap.
5. clr priority:
   - Stimulus: assert clr in the same cycle as a mismatching compare.
   - Required: err=1 next cycle, but err_cnt=0, chk_cnt=0, err_sticky=0.
   - The next matching compare gives chk_cnt=1.
6. Reset mid-stream:
   - Stimulus: rst_n=0 for one cycle with v1=v2=1 and a wrong `o` pending.
   - Required: all outputs 0, and no err during the next 2 cycles.
